// File: rtl/regs_uart_fifo_if.sv
// Local register bus for the UART CSR block: write channel, read request and registered read return.
interface regs_uart_fifo_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wen;
    logic [STRB_W-1:0] wstrb;
    logic              wready;
    logic [ADDR_W-1:0] raddr;
    logic              ren;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output waddr, wdata, wen, wstrb, raddr, ren,
        input  wready, rdata, rvalid
    );

    modport slave (
        input  waddr, wdata, wen, wstrb, raddr, ren,
        output wready, rdata, rvalid
    );
endinterface

// File: rtl/regs_uart_fifo.sv
// UART CSR block: TX/RX character FIFOs, control, sticky status flags, baud divisor and interrupt.
module regs_uart_fifo #(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int          STRB_W     = DATA_W / 8,
    parameter int          CHAR_W     = 8,
    parameter int          TX_DEPTH   = 16,
    parameter int          RX_DEPTH   = 16,
    parameter logic [15:0] BAUD_RESET = 16'd434
) (
    input  logic              clk,
    input  logic              rst,
    regs_uart_fifo_if.slave   bus,
    output logic [CHAR_W-1:0] tx_data_out,
    output logic              tx_valid_out,
    input  logic              tx_ready_in,
    input  logic              tx_done_in,
    input  logic [CHAR_W-1:0] rx_data_in,
    input  logic              rx_valid_in,
    output logic [15:0]       baud_div_out,
    output logic              irq_out
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_LW = TX_AW + 1;
    localparam int RX_LW = RX_AW + 1;
    localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(32'h0);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(32'h4);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(32'h8);
    localparam logic [ADDR_W-1:0] A_BAUD = ADDR_W'(32'hC);

    logic [CHAR_W-1:0] tx_mem_q [TX_DEPTH];
    logic [CHAR_W-1:0] rx_mem_q [RX_DEPTH];
    logic [TX_AW-1:0]  tx_wptr_q, tx_rptr_q;
    logic [RX_AW-1:0]  rx_wptr_q, rx_rptr_q;
    logic [TX_LW-1:0]  tx_lvl_q;
    logic [RX_LW-1:0]  rx_lvl_q;
    logic              tx_en_q, rx_en_q;
    logic [2:0]        ie_q;
    logic              tx_ovf_q, rx_ovf_q, tx_done_q;
    logic [15:0]       baud_q;
    logic              ren_q, rvalid_q, irq_q;
    logic [DATA_W-1:0] rdata_q;

    logic tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
    logic wr_data_s, wr_ctrl_s, wr_baud_s, tx_flush_s, rx_flush_s;
    logic rd_first_s, rd_data_s, rd_stat_s;
    logic tx_push_s, tx_pop_s, tx_ovf_set_s, rx_push_s, rx_pop_s, rx_ovf_set_s;
    logic irq_d;
    logic [15:0]       baud_d;
    logic [31:0]       stat_s;
    logic [DATA_W-1:0] rd_mux_s;
    logic              unused_s;

    assign tx_empty_s = (tx_lvl_q == TX_LW'(0));
    assign tx_full_s  = (tx_lvl_q == TX_LW'(TX_DEPTH));
    assign rx_empty_s = (rx_lvl_q == RX_LW'(0));
    assign rx_full_s  = (rx_lvl_q == RX_LW'(RX_DEPTH));

    assign wr_data_s  = bus.wen && (bus.waddr == A_DATA) && bus.wstrb[0];
    assign wr_ctrl_s  = bus.wen && (bus.waddr == A_CTRL) && bus.wstrb[0];
    assign wr_baud_s  = bus.wen && (bus.waddr == A_BAUD) && (bus.wstrb[1:0] != 2'b00);
    assign tx_flush_s = wr_ctrl_s && bus.wdata[2];
    assign rx_flush_s = wr_ctrl_s && bus.wdata[3];

    // Side effects of a read fire only on its first cycle, so a held ren acts once.
    assign rd_first_s = bus.ren && !ren_q;
    assign rd_data_s  = rd_first_s && (bus.raddr == A_DATA);
    assign rd_stat_s  = rd_first_s && (bus.raddr == A_STAT);

    // A push into a full FIFO is dropped even if the core pops in the same cycle.
    assign tx_pop_s     = tx_valid_out && tx_ready_in && !tx_flush_s;
    assign tx_push_s    = wr_data_s && !tx_full_s && !tx_flush_s;
    assign tx_ovf_set_s = wr_data_s && tx_full_s && !tx_flush_s;
    assign rx_pop_s     = rd_data_s && !rx_empty_s && !rx_flush_s;
    assign rx_push_s    = rx_valid_in && rx_en_q && !rx_full_s && !rx_flush_s;
    assign rx_ovf_set_s = rx_valid_in && rx_en_q && rx_full_s && !rx_flush_s;

    assign bus.wready   = 1'b1;
    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;
    assign baud_div_out = baud_q;
    assign irq_out      = irq_q;
    assign tx_valid_out = !tx_empty_s && tx_en_q;
    assign unused_s     = ^{bus.wdata[DATA_W-1:16], bus.wstrb[STRB_W-1:2]};

    // TX head is shown only while the FIFO holds data so reset and empty read as zero.
    always_comb begin
        tx_data_out = '0;
        if (!tx_empty_s) begin
            tx_data_out = tx_mem_q[tx_rptr_q];
        end else begin
            tx_data_out = '0;
        end
    end

    // Byte-wise BAUD merge; a zero divisor would stall the baud generator, so store 1 instead.
    always_comb begin
        baud_d = baud_q;
        if (bus.wstrb[0]) begin
            baud_d[7:0] = bus.wdata[7:0];
        end else begin
            baud_d[7:0] = baud_q[7:0];
        end
        if (bus.wstrb[1]) begin
            baud_d[15:8] = bus.wdata[15:8];
        end else begin
            baud_d[15:8] = baud_q[15:8];
        end
        if (baud_d == 16'd0) begin
            baud_d = 16'd1;
        end else begin
            baud_d = baud_d;
        end
    end

    // Read-data mux and interrupt source, both taken from state before this cycle's side effects.
    always_comb begin
        stat_s = {8'h00, 8'(rx_lvl_q), 8'(tx_lvl_q), 1'b0, tx_done_q, rx_ovf_q, tx_ovf_q,
                  rx_full_s, rx_empty_s, tx_empty_s, tx_full_s};
        irq_d  = (ie_q[0] && tx_empty_s) || (ie_q[1] && !rx_empty_s) ||
                 (ie_q[2] && (tx_ovf_q || rx_ovf_q));
        case (bus.raddr)
            A_DATA:  rd_mux_s = rx_empty_s ? '0 : DATA_W'(rx_mem_q[rx_rptr_q]);
            A_STAT:  rd_mux_s = DATA_W'(stat_s);
            A_CTRL:  rd_mux_s = DATA_W'({ie_q, 2'b00, rx_en_q, tx_en_q});
            A_BAUD:  rd_mux_s = DATA_W'(baud_q);
            default: rd_mux_s = '0;
        endcase
    end

    // FIFO storage; contents are qualified by the levels, so no reset is needed.
    always_ff @(posedge clk) begin
        if (tx_push_s) tx_mem_q[tx_wptr_q] <= bus.wdata[CHAR_W-1:0];
        if (rx_push_s) rx_mem_q[rx_wptr_q] <= rx_data_in;
    end

    // FIFO pointers and levels; flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr_q <= '0; tx_rptr_q <= '0; tx_lvl_q <= '0;
            rx_wptr_q <= '0; rx_rptr_q <= '0; rx_lvl_q <= '0;
        end else begin
            if (tx_flush_s) begin
                tx_wptr_q <= '0; tx_rptr_q <= '0; tx_lvl_q <= '0;
            end else begin
                if (tx_push_s) tx_wptr_q <= tx_wptr_q + TX_AW'(1);
                if (tx_pop_s)  tx_rptr_q <= tx_rptr_q + TX_AW'(1);
                tx_lvl_q <= tx_lvl_q + TX_LW'(tx_push_s) - TX_LW'(tx_pop_s);
            end
            if (rx_flush_s) begin
                rx_wptr_q <= '0; rx_rptr_q <= '0; rx_lvl_q <= '0;
            end else begin
                if (rx_push_s) rx_wptr_q <= rx_wptr_q + RX_AW'(1);
                if (rx_pop_s)  rx_rptr_q <= rx_rptr_q + RX_AW'(1);
                rx_lvl_q <= rx_lvl_q + RX_LW'(rx_push_s) - RX_LW'(rx_pop_s);
            end
        end
    end

    // Control, baud and sticky flags; a flag set in the cycle it is read stays set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_en_q   <= 1'b1;
            rx_en_q   <= 1'b1;
            ie_q      <= 3'b000;
            baud_q    <= BAUD_RESET;
            tx_ovf_q  <= 1'b0;
            rx_ovf_q  <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                tx_en_q <= bus.wdata[0];
                rx_en_q <= bus.wdata[1];
                ie_q    <= bus.wdata[6:4];
            end
            if (wr_baud_s) baud_q <= baud_d;
            tx_ovf_q  <= tx_ovf_set_s || (tx_ovf_q && !rd_stat_s);
            rx_ovf_q  <= rx_ovf_set_s || (rx_ovf_q && !rd_stat_s);
            tx_done_q <= tx_done_in   || (tx_done_q && !rd_stat_s);
        end
    end

    // Registered read return, first-cycle read detector and interrupt output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ren_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            ren_q    <= bus.ren;
            rvalid_q <= bus.ren;
            rdata_q  <= bus.ren ? rd_mux_s : '0;
            irq_q    <= irq_d;
        end
    end
endmodule

// File: tb/tb_regs_uart_fifo.sv
// Directed self-checking bench for regs_uart_fifo with hand-computed expected values.
module tb_regs_uart_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data_out, rx_data_in;
    logic       tx_valid_out, tx_ready_in, tx_done_in, rx_valid_in, irq_out;
    logic [15:0] baud_div_out;
    logic [31:0] d;
    int checks_cnt = 0;
    int fail_cnt   = 0;

    regs_uart_fifo_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    regs_uart_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if),
        .tx_data_out  (tx_data_out),
        .tx_valid_out (tx_valid_out),
        .tx_ready_in  (tx_ready_in),
        .tx_done_in   (tx_done_in),
        .rx_data_in   (rx_data_in),
        .rx_valid_in  (rx_valid_in),
        .baud_div_out (baud_div_out),
        .irq_out      (irq_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
        bus_if.waddr = a; bus_if.wdata = v; bus_if.wstrb = s; bus_if.wen = 1'b1;
        tick();
        bus_if.wen = 1'b0; bus_if.wstrb = 4'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus_if.raddr = a; bus_if.ren = 1'b1;
        tick();
        bus_if.ren = 1'b0;
        check_eq(tag, bus_if.rdata, exp);
        tick();
    endtask

    task automatic rx_push(input logic [7:0] v);
        rx_data_in = v; rx_valid_in = 1'b1;
        tick();
        rx_valid_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus_if.waddr = 32'h0; bus_if.wdata = 32'h0; bus_if.wen = 1'b0; bus_if.wstrb = 4'h0;
        bus_if.raddr = 32'h0; bus_if.ren = 1'b0;
        tx_ready_in = 1'b0; tx_done_in = 1'b0; rx_data_in = 8'h00; rx_valid_in = 1'b0;
        #2;
        check_eq("rst_tx_valid", 32'(tx_valid_out), 32'd0);
        check_eq("rst_tx_data",  32'(tx_data_out), 32'd0);
        check_eq("rst_irq",      32'(irq_out), 32'd0);
        check_eq("rst_rvalid",   32'(bus_if.rvalid), 32'd0);
        check_eq("rst_baud_out", 32'(baud_div_out), 32'd434);
        check_eq("wready",       32'(bus_if.wready), 32'd1);
        tick(); tick();
        rst = 1'b0;
        tick();
        rd_chk("rst_stat", 32'h4, 32'h0000_0006);
        rd_chk("rst_baud", 32'hC, 32'd434);
        rd_chk("rst_ctrl", 32'h8, 32'h0000_0003);

        // TX push three, then drain in order
        wr(32'h0, 32'h41, 4'h1); wr(32'h0, 32'h42, 4'h1); wr(32'h0, 32'h43, 4'h1);
        rd_chk("tx_lvl3_stat", 32'h4, 32'h0000_0304);
        tx_ready_in = 1'b1;
        check_eq("tx_head0", 32'(tx_data_out), 32'h41);
        check_eq("tx_valid0", 32'(tx_valid_out), 32'd1);
        tick(); check_eq("tx_head1", 32'(tx_data_out), 32'h42);
        tick(); check_eq("tx_head2", 32'(tx_data_out), 32'h43);
        tick(); tx_ready_in = 1'b0;
        check_eq("tx_drained_valid", 32'(tx_valid_out), 32'd0);
        rd_chk("tx_drained_stat", 32'h4, 32'h0000_0006);

        // TX overflow and read-to-clear
        for (int i = 0; i < 17; i++) wr(32'h0, 32'h60 + 32'(i), 4'h1);
        check_eq("tx_full_head", 32'(tx_data_out), 32'h60);
        rd_chk("tx_ovf_stat1", 32'h4, 32'h0000_1015);
        rd_chk("tx_ovf_stat2", 32'h4, 32'h0000_1005);
        wr(32'h0, 32'hEE, 4'h1);
        wr(32'h8, 32'h07, 4'h1);
        for (int i = 0; i < 5; i++) wr(32'h0, 32'h70 + 32'(i), 4'h1);
        check_eq("tx5_head", 32'(tx_data_out), 32'h70);
        wr(32'h8, 32'h07, 4'h1);
        check_eq("flush_valid", 32'(tx_valid_out), 32'd0);
        rd_chk("flush_stat", 32'h4, 32'h0000_0016);
        rd_chk("flush_stat2", 32'h4, 32'h0000_0006);
        rd_chk("flush_ctrl", 32'h8, 32'h0000_0003);

        // TX_EN clear holds valid low and keeps contents
        wr(32'h0, 32'h77, 4'h1);
        wr(32'h8, 32'h02, 4'h1);
        check_eq("txen0_valid", 32'(tx_valid_out), 32'd0);
        tx_ready_in = 1'b1; tick(); tx_ready_in = 1'b0;
        wr(32'h8, 32'h03, 4'h1);
        check_eq("txen1_valid", 32'(tx_valid_out), 32'd1);
        check_eq("txen1_head", 32'(tx_data_out), 32'h77);
        tx_ready_in = 1'b1; tick(); tx_ready_in = 1'b0;
        check_eq("txen_popped", 32'(tx_valid_out), 32'd0);

        // RX push/pop, empty read, held read
        rx_push(8'h5A); rx_push(8'hA5);
        rd_chk("rx_pop0", 32'h0, 32'h5A);
        rd_chk("rx_pop1", 32'h0, 32'hA5);
        rd_chk("rx_empty_rd", 32'h0, 32'h00);
        rx_push(8'h11); rx_push(8'h22);
        bus_if.raddr = 32'h0; bus_if.ren = 1'b1;
        tick();
        check_eq("held_rd_data", bus_if.rdata, 32'h11);
        check_eq("held_rd_rvalid", 32'(bus_if.rvalid), 32'd1);
        tick(); tick();
        bus_if.ren = 1'b0;
        tick();
        check_eq("rvalid_low", 32'(bus_if.rvalid), 32'd0);
        check_eq("rdata_low", bus_if.rdata, 32'd0);
        rd_chk("held_rd_stat", 32'h4, 32'h0001_0002);
        rd_chk("held_rd_next", 32'h0, 32'h22);

        // RX overflow, flush, RX_EN
        for (int i = 0; i < 17; i++) rx_push(8'h30 + 8'(i));
        rd_chk("rx_ovf_stat1", 32'h4, 32'h0010_002A);
        rd_chk("rx_ovf_stat2", 32'h4, 32'h0010_000A);
        rd_chk("rx_full_head", 32'h0, 32'h30);
        wr(32'h8, 32'h0B, 4'h1);
        rd_chk("rx_flush_stat", 32'h4, 32'h0000_0006);
        wr(32'h8, 32'h01, 4'h1);
        rx_push(8'h99);
        rd_chk("rxen0_stat", 32'h4, 32'h0000_0006);
        wr(32'h8, 32'h03, 4'h1);

        // Interrupt timing
        wr(32'h8, 32'h23, 4'h1);
        rx_push(8'h55);
        check_eq("irq_rx_1cyc", 32'(irq_out), 32'd0);
        tick();
        check_eq("irq_rx_2cyc", 32'(irq_out), 32'd1);
        bus_if.raddr = 32'h0; bus_if.ren = 1'b1;
        tick();
        bus_if.ren = 1'b0;
        check_eq("irq_rx_data", bus_if.rdata, 32'h55);
        check_eq("irq_drain_1", 32'(irq_out), 32'd1);
        tick();
        check_eq("irq_drain_2", 32'(irq_out), 32'd0);
        wr(32'h8, 32'h13, 4'h1);
        check_eq("irq_txe_1", 32'(irq_out), 32'd0);
        tick();
        check_eq("irq_txe_2", 32'(irq_out), 32'd1);
        wr(32'h8, 32'h43, 4'h1);
        tick();
        check_eq("irq_ovf_idle", 32'(irq_out), 32'd0);
        for (int i = 0; i < 17; i++) wr(32'h0, 32'h10, 4'h1);
        tick();
        check_eq("irq_ovf", 32'(irq_out), 32'd1);
        rd_chk("irq_ovf_stat", 32'h4, 32'h0000_1015);
        check_eq("irq_ovf_clr", 32'(irq_out), 32'd0);
        wr(32'h8, 32'h07, 4'h1);
        wr(32'h8, 32'h03, 4'h1);

        // BAUD
        wr(32'hC, 32'h0, 4'hF);
        rd_chk("baud_zero", 32'hC, 32'd1);
        check_eq("baud_zero_out", 32'(baud_div_out), 32'd1);
        wr(32'hC, 32'h01B2, 4'h3);
        wr(32'hC, 32'h1234, 4'h1);
        rd_chk("baud_lo", 32'hC, 32'h0134);
        wr(32'hC, 32'hAB00, 4'h2);
        check_eq("baud_hi_out", 32'(baud_div_out), 32'hAB34);

        // TX_DONE sticky
        tx_done_in = 1'b1; tick(); tx_done_in = 1'b0;
        rd_chk("txdone_stat1", 32'h4, 32'h0000_0046);
        rd_chk("txdone_stat2", 32'h4, 32'h0000_0006);

        // Reset mid-transfer
        wr(32'h0, 32'hAA, 4'h1); wr(32'h0, 32'hBB, 4'h1);
        check_eq("pre_rst_valid", 32'(tx_valid_out), 32'd1);
        #3 rst = 1'b1;
        #1;
        check_eq("async_rst_valid", 32'(tx_valid_out), 32'd0);
        check_eq("async_rst_data", 32'(tx_data_out), 32'd0);
        check_eq("async_rst_baud", 32'(baud_div_out), 32'd434);
        tick();
        rst = 1'b0;
        tick();
        rd_chk("post_rst_stat", 32'h4, 32'h0000_0006);
        rd_chk("post_rst_ctrl", 32'h8, 32'h0000_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/regs_uart_fifo.md
# regs_uart_fifo

Parametrised CSR block for the next-generation UART in the picoSoC peripheral set. It replaces the single-byte data register and one-shot start strobe with separate TX and RX FIFOs, a programmable baud divisor, sticky error flags and a level-sensitive interrupt. It sits between the local register bus and the UART TX/RX cores. The cores exchange characters with it through valid/ready handshakes.

## Interface
- ADDR_W, 32: bus address width.
- DATA_W, 32: bus data width.
- STRB_W, DATA_W/8: write strobe width.
- CHAR_W, 8: character width, 5..8.
- TX_DEPTH, 16: TX FIFO entries; power of two, 2..128.
- RX_DEPTH, 16: RX FIFO entries; power of two, 2..128.
- BAUD_RESET, 16'd434: reset value of the baud divisor.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- tx_data_out  out  CHAR_W  TX FIFO head.
- tx_valid_out  out  1  head valid: TX FIFO not empty and TX_EN=1.
- tx_ready_in  in  1  TX core accepts the head; pops the FIFO when tx_valid_out is also high.
- tx_done_in  in  1  one-cycle pulse at the end of each stop bit.
- rx_data_in  in  CHAR_W  received character.
- rx_valid_in  in  1  one-cycle pulse; pushes rx_data_in when RX_EN=1.
- baud_div_out  out  16  BAUD register value.
- irq_out  out  1  registered interrupt request.
- Local bus ports, all DATA_W/ADDR_W/STRB_W wide as named: waddr, wdata, wen, wstrb, wready (out), raddr, ren, rdata (out), rvalid (out).

## Operation
Register map (byte addresses; unlisted bits read 0):
- **0x0 DATA**
  - Write with wstrb[0]=1 pushes wdata[CHAR_W-1:0] into the TX FIFO.
  - Read pops the RX FIFO and returns the popped character in [CHAR_W-1:0].
  - Read with RX empty returns 0 and changes nothing.
- **0x4 STAT** (ro unless marked)
  - [0] TX_FULL, [1] TX_EMPTY, [2] RX_EMPTY, [3] RX_FULL.
  - [4] TX_OVF, roc: push attempted while TX full.
  - [5] RX_OVF, roc: rx_valid_in while RX full.
  - [6] TX_DONE, roc: sticky capture of tx_done_in.
  - [15:8] TX_LEVEL, [23:16] RX_LEVEL: zero-extended entry counts.
- **0x8 CTRL** (byte 0)
  - [0] TX_EN, rw, reset 1. [1] RX_EN, rw, reset 1.
  - [2] TX_FLUSH, wosc, reads 0. [3] RX_FLUSH, wosc, reads 0.
  - [4] IE_TXEMPTY, rw, reset 0. [5] IE_RXAVAIL, rw, reset 0. [6] IE_OVF, rw, reset 0.
- **0xC BAUD**: [15:0] divisor, rw; wstrb[0] updates the low byte, wstrb[1] the high byte. A written value of 0 is stored as 1.

Rules:
- Read side effects (RX pop, roc clear) fire only on the first cycle of a read, i.e. ren && addr match && !ren_ff. A held ren causes no repeated pops or clears.
- TX full: the push is dropped and TX_OVF is set, even if tx_ready_in pops in the same cycle.
- RX full: the character is dropped and RX_OVF is set.
- Simultaneous push and pop on a FIFO that is not full: level unchanged, both take effect.
- An roc flag being set and cleared in the same cycle ends up set.
- Flush zeroes the pointers and level of the selected FIFO. It takes priority over a same-cycle push or pop and sets no overflow flag.
- Clearing TX_EN holds tx_valid_out low; FIFO contents are kept.
- Clearing RX_EN ignores rx_valid_in; no overflow is recorded.
- irq_out (registered) = (IE_TXEMPTY & TX_EMPTY) | (IE_RXAVAIL & !RX_EMPTY) | (IE_OVF & (TX_OVF | RX_OVF)).
- Pointers use log2(DEPTH) bits and wrap modulo DEPTH. Levels use log2(DEPTH)+1 bits and range 0..DEPTH.

## Timing
- wready is tied to 1. Writes take effect on the clock edge where wen is high.
- rdata and rvalid are registered and valid in the cycle after ren; both are 0 when ren was low. rdata reflects state before that cycle's side effects.
- tx_data_out is combinational from the FIFO head. A pop is visible on the next cycle.
- A FIFO push is visible in STAT and in tx_valid_out/irq state one cycle later. irq_out adds one further cycle.
- Reset values (asynchronous, immediate):
  - FIFOs empty; all flags 0; CTRL = 0x03; BAUD = BAUD_RESET.
  - tx_valid_out=0, tx_data_out=0, irq_out=0, rdata=0, rvalid=0.
- Reset mid-transfer discards all FIFO contents. No pop is reported to the core.

## Test plan
- Reset, then read 0x4 and 0xC → STAT=0x00000006, BAUD=434; tx_valid_out=0, irq_out=0.
- Write 0x41, 0x42, 0x43 to 0x0 with tx_ready_in=0 → TX_LEVEL=3. Then raise tx_ready_in → tx_data_out steps 0x41, 0x42, 0x43, after which tx_valid_out=0 and TX_EMPTY=1.
- With TX_DEPTH=16, 17 writes and no pops → TX_FULL=1, TX_OVF=1, level 16. The first read of STAT returns bit4=1; the second read returns bit4=0.
- Pulse rx_valid_in with 0x5A then 0xA5 → reads of 0x0 return 0x5A then 0xA5. A third read returns 0. A read with ren held 3 cycles pops exactly one entry.
- Write CTRL=0x23 → irq_out goes high 2 cycles after the first RX push and drops 2 cycles after the RX FIFO drains. Write CTRL=0x07 with TX level 5 → TX_LEVEL=0 and TX_OVF unchanged.
- Write BAUD=0 → reads 1 and baud_div_out=1. Write 0x1234 with wstrb=0x1 from reset value 434 (0x01B2) → BAUD=0x0134.
